abp_receiver_ctrl: RTL and testbench

Sequencing controller for the receiver side of the Alternating Bit Protocol. It takes decoded packets from the packet receiver and checks each sequence bit against the locally held expected bit. New data goes to the downstream consumer; duplicates are dropped. Every good packet is acknowledged with a one-byte AXI-Stream ACK frame. The block owns the expected-bit state that the packet receiver consumes, and keeps saturating statistics counters.

---
 rtl/abp_receiver_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_abp_receiver_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/abp_receiver_ctrl.sv
// Receiver-side Alternating Bit Protocol sequencer: classifies decoded packets,
// delivers new payloads, re-ACKs duplicates and keeps saturating statistics.
module abp_receiver_ctrl #(
  parameter logic [7:0] ACK_BASE = 8'hA0,
  parameter int         CNT_W    = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic             pkt_bit,
  input  logic [63:0]      pkt_value,
  input  logic             pkt_err,
  output logic             expected_bit,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [63:0]      m_value,
  output logic             ack_tvalid,
  input  logic             ack_tready,
  output logic [7:0]       ack_tdata,
  output logic             ack_tlast,
  output logic [CNT_W-1:0] cnt_new,
  output logic [CNT_W-1:0] cnt_dup,
  output logic [CNT_W-1:0] cnt_err
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CHECK    = 2'd1;
  localparam logic [1:0] S_DELIVER  = 2'd2;
  localparam logic [1:0] S_SEND_ACK = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,      state_d;
  logic             pkt_ready_q,  pkt_ready_d;
  logic             bit_q,        bit_d;
  logic [63:0]      val_q,        val_d;
  logic             err_q,        err_d;
  logic             is_new_q,     is_new_d;
  logic             exp_q,        exp_d;
  logic             m_valid_q,    m_valid_d;
  logic [63:0]      m_value_q,    m_value_d;
  logic             ack_tvalid_q, ack_tvalid_d;
  logic [7:0]       ack_tdata_q,  ack_tdata_d;
  logic             ack_tlast_q,  ack_tlast_d;
  logic [CNT_W-1:0] cnt_new_q,    cnt_new_d;
  logic [CNT_W-1:0] cnt_dup_q,    cnt_dup_d;
  logic [CNT_W-1:0] cnt_err_q,    cnt_err_d;

  // Statistics stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  function automatic logic [7:0] ack_byte(input logic b);
    return ACK_BASE | {7'd0, b};
  endfunction

  always_comb begin
    state_d      = state_q;
    pkt_ready_d  = pkt_ready_q;
    bit_d        = bit_q;
    val_d        = val_q;
    err_d        = err_q;
    is_new_d     = is_new_q;
    exp_d        = exp_q;
    m_valid_d    = m_valid_q;
    m_value_d    = m_value_q;
    ack_tvalid_d = ack_tvalid_q;
    ack_tdata_d  = ack_tdata_q;
    ack_tlast_d  = ack_tlast_q;
    cnt_new_d    = cnt_new_q;
    cnt_dup_d    = cnt_dup_q;
    cnt_err_d    = cnt_err_q;

    case (state_q)
      S_IDLE: begin
        if (pkt_valid && pkt_ready_q) begin
          bit_d       = pkt_bit;
          val_d       = pkt_value;
          err_d       = pkt_err;
          pkt_ready_d = 1'b0;
          state_d     = S_CHECK;
        end
      end

      S_CHECK: begin
        // A malformed packet is dropped before its sequence bit is even looked at.
        if (err_q) begin
          cnt_err_d   = sat_inc(cnt_err_q);
          pkt_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else if (bit_q == exp_q) begin
          m_value_d = val_q;
          m_valid_d = 1'b1;
          state_d   = S_DELIVER;
        end else begin
          cnt_dup_d    = sat_inc(cnt_dup_q);
          is_new_d     = 1'b0;
          ack_tvalid_d = 1'b1;
          ack_tlast_d  = 1'b1;
          ack_tdata_d  = ack_byte(bit_q);
          state_d      = S_SEND_ACK;
        end
      end

      S_DELIVER: begin
        // The ACK for new data is only raised once the consumer has taken it.
        if (m_ready) begin
          m_valid_d    = 1'b0;
          cnt_new_d    = sat_inc(cnt_new_q);
          is_new_d     = 1'b1;
          ack_tvalid_d = 1'b1;
          ack_tlast_d  = 1'b1;
          ack_tdata_d  = ack_byte(bit_q);
          state_d      = S_SEND_ACK;
        end
      end

      S_SEND_ACK: begin
        if (ack_tready) begin
          ack_tvalid_d = 1'b0;
          ack_tlast_d  = 1'b0;
          ack_tdata_d  = 8'd0;
          pkt_ready_d  = 1'b1;
          state_d      = S_IDLE;
          if (is_new_q) begin
            exp_d = ~exp_q;
          end
        end
      end

      default: begin
        pkt_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      pkt_ready_q  <= 1'b1;
      bit_q        <= 1'b0;
      val_q        <= 64'd0;
      err_q        <= 1'b0;
      is_new_q     <= 1'b0;
      exp_q        <= 1'b0;
      m_valid_q    <= 1'b0;
      m_value_q    <= 64'd0;
      ack_tvalid_q <= 1'b0;
      ack_tdata_q  <= 8'd0;
      ack_tlast_q  <= 1'b0;
      cnt_new_q    <= '0;
      cnt_dup_q    <= '0;
      cnt_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      pkt_ready_q  <= pkt_ready_d;
      bit_q        <= bit_d;
      val_q        <= val_d;
      err_q        <= err_d;
      is_new_q     <= is_new_d;
      exp_q        <= exp_d;
      m_valid_q    <= m_valid_d;
      m_value_q    <= m_value_d;
      ack_tvalid_q <= ack_tvalid_d;
      ack_tdata_q  <= ack_tdata_d;
      ack_tlast_q  <= ack_tlast_d;
      cnt_new_q    <= cnt_new_d;
      cnt_dup_q    <= cnt_dup_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

  assign pkt_ready    = pkt_ready_q;
  assign expected_bit = exp_q;
  assign m_valid      = m_valid_q;
  assign m_value      = m_value_q;
  assign ack_tvalid   = ack_tvalid_q;
  assign ack_tdata    = ack_tdata_q;
  assign ack_tlast    = ack_tlast_q;
  assign cnt_new      = cnt_new_q;
  assign cnt_dup      = cnt_dup_q;
  assign cnt_err      = cnt_err_q;

endmodule

// File: tb/tb_abp_receiver_ctrl.sv
// Bench for abp_receiver_ctrl: a 16-bit-counter instance and a 2-bit-counter
// instance share all inputs; vectors, corner sequences and a random run vs. a model.
module tb_abp_receiver_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  always #5 aclk = ~aclk;

  logic        pkt_valid, pkt_bit, pkt_err, m_ready, ack_tready;
  logic [63:0] pkt_value;

  logic        pkt_ready, expected_bit, m_valid, ack_tvalid, ack_tlast;
  logic [63:0] m_value;
  logic [7:0]  ack_tdata;
  logic [15:0] cnt_new, cnt_dup, cnt_err;

  logic        s_pkt_ready, s_expected_bit, s_m_valid, s_ack_tvalid, s_ack_tlast;
  logic [63:0] s_m_value;
  logic [7:0]  s_ack_tdata;
  logic [1:0]  s_cnt_new, s_cnt_dup, s_cnt_err;

  abp_receiver_ctrl #(.ACK_BASE(8'hA0), .CNT_W(16)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_bit(pkt_bit),
    .pkt_value(pkt_value), .pkt_err(pkt_err), .expected_bit(expected_bit),
    .m_valid(m_valid), .m_ready(m_ready), .m_value(m_value),
    .ack_tvalid(ack_tvalid), .ack_tready(ack_tready), .ack_tdata(ack_tdata),
    .ack_tlast(ack_tlast), .cnt_new(cnt_new), .cnt_dup(cnt_dup), .cnt_err(cnt_err)
  );

  abp_receiver_ctrl #(.ACK_BASE(8'hA0), .CNT_W(2)) u_sat (
    .aclk(aclk), .aresetn(aresetn),
    .pkt_valid(pkt_valid), .pkt_ready(s_pkt_ready), .pkt_bit(pkt_bit),
    .pkt_value(pkt_value), .pkt_err(pkt_err), .expected_bit(s_expected_bit),
    .m_valid(s_m_valid), .m_ready(m_ready), .m_value(s_m_value),
    .ack_tvalid(s_ack_tvalid), .ack_tready(ack_tready), .ack_tdata(s_ack_tdata),
    .ack_tlast(s_ack_tlast), .cnt_new(s_cnt_new), .cnt_dup(s_cnt_dup), .cnt_err(s_cnt_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic chk_cnts(input string tag, input int n, input int d, input int e);
    chk({tag, "_cnt_new"}, 64'(cnt_new), 64'(n));
    chk({tag, "_cnt_dup"}, 64'(cnt_dup), 64'(d));
    chk({tag, "_cnt_err"}, 64'(cnt_err), 64'(e));
    chk({tag, "_sat_new"}, 64'(s_cnt_new), 64'(sat3(n)));
    chk({tag, "_sat_dup"}, 64'(s_cnt_dup), 64'(sat3(d)));
    chk({tag, "_sat_err"}, 64'(s_cnt_err), 64'(sat3(e)));
  endtask

  typedef struct {
    logic        b;
    logic        e;
    logic [63:0] v;
    int          mst;
    int          ast;
    logic        exp_del;
    logic        exp_ack;
    logic [7:0]  exp_byte;
    logic        exp_ebit;
    int          exp_cyc;
    int          exp_new;
    int          exp_dup;
    int          exp_err;
  } vec_t;

  typedef struct packed {
    logic        del;
    logic [63:0] dval;
    logic        ack;
    logic [7:0]  abyte;
    logic        alast_bad;
    int          cyc;
    logic        unstable;
    logic        order_bad;
    logic        timeout;
  } obs_t;

  // Offer one packet, stall the consumer/ACK sink as asked, observe until idle again.
  task automatic send(input logic b, input logic e, input logic [63:0] v,
                      input int mst, input int ast, output obs_t o);
    int mlow;
    int alow;
    int wait_cyc;
    logic [63:0] mv0;
    logic [7:0]  ab0;
    o = '0;
    mlow = 0;
    alow = 0;
    mv0 = '0;
    ab0 = '0;
    @(negedge aclk);
    pkt_valid  = 1'b1;
    pkt_bit    = b;
    pkt_err    = e;
    pkt_value  = v;
    m_ready    = (mst == 0);
    ack_tready = (ast == 0);
    wait_cyc = 0;
    while (!pkt_ready && wait_cyc < 50) begin
      @(negedge aclk);
      wait_cyc++;
    end
    @(posedge aclk);
    #1;
    pkt_valid = 1'b0;
    pkt_value = ~v;
    pkt_bit   = ~b;
    o.timeout = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge aclk);
      if (pkt_ready) begin
        o.cyc = c;
        o.timeout = 1'b0;
        break;
      end
      if (m_valid) begin
        if (o.ack || ack_tvalid) o.order_bad = 1'b1;
        if (!o.del) mv0 = m_value;
        else if (m_value !== mv0) o.unstable = 1'b1;
        o.del  = 1'b1;
        o.dval = m_value;
        m_ready = (mlow >= mst);
        if (mlow < mst) mlow++;
      end
      if (ack_tvalid) begin
        if (!ack_tlast) o.alast_bad = 1'b1;
        if (!o.ack) ab0 = ack_tdata;
        else if (ack_tdata !== ab0) o.unstable = 1'b1;
        o.ack   = 1'b1;
        o.abyte = ack_tdata;
        ack_tready = (alow >= ast);
        if (alow < ast) alow++;
      end
    end
  endtask

  vec_t vecs[11];
  obs_t ob;

  logic [63:0] dq[$];
  logic [7:0]  aq[$];
  logic        mexp;
  int          mnew, mdup, merr, sent;
  logic        acc, prev_mstall, prev_astall;
  logic [63:0] prev_mval;
  logic [7:0]  prev_abyte;
  localparam int NRAND = 200;

  initial begin
    aresetn    = 1'b1;
    pkt_valid  = 1'b0;
    pkt_bit    = 1'b0;
    pkt_err    = 1'b0;
    pkt_value  = '0;
    m_ready    = 1'b1;
    ack_tready = 1'b1;

    // Expected state after the hand-written first packet: exp=1, new=1.
    vecs[0]  = '{1'b0, 1'b0, 64'h1,                   0,  0, 1'b0, 1'b1, 8'hA0, 1'b1,  3, 1, 1, 0};
    vecs[1]  = '{1'b1, 1'b0, 64'hAAAA_0000_1111_2222, 0,  0, 1'b1, 1'b1, 8'hA1, 1'b0,  4, 2, 1, 0};
    vecs[2]  = '{1'b0, 1'b0, 64'hBBBB_3333_4444_5555, 0,  0, 1'b1, 1'b1, 8'hA0, 1'b1,  4, 3, 1, 0};
    vecs[3]  = '{1'b1, 1'b0, 64'hCCCC_6666_7777_8888, 10, 5, 1'b1, 1'b1, 8'hA1, 1'b0, 19, 4, 1, 0};
    vecs[4]  = '{1'b0, 1'b1, 64'hE0,                  0,  0, 1'b0, 1'b0, 8'h00, 1'b0,  2, 4, 1, 1};
    vecs[5]  = '{1'b1, 1'b1, 64'hE1,                  0,  0, 1'b0, 1'b0, 8'h00, 1'b0,  2, 4, 1, 2};
    vecs[6]  = '{1'b0, 1'b1, 64'hE2,                  0,  0, 1'b0, 1'b0, 8'h00, 1'b0,  2, 4, 1, 3};
    vecs[7]  = '{1'b1, 1'b1, 64'hE3,                  0,  0, 1'b0, 1'b0, 8'h00, 1'b0,  2, 4, 1, 4};
    vecs[8]  = '{1'b0, 1'b1, 64'hE4,                  0,  0, 1'b0, 1'b0, 8'h00, 1'b0,  2, 4, 1, 5};
    vecs[9]  = '{1'b1, 1'b0, 64'h99,                  0,  3, 1'b0, 1'b1, 8'hA1, 1'b0,  6, 4, 2, 5};
    vecs[10] = '{1'b0, 1'b0, 64'hDDDD_9999_AAAA_BBBB, 0,  2, 1'b1, 1'b1, 8'hA0, 1'b1,  6, 5, 2, 5};

    // Power-on reset values
    #1 aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    chk("rst_pkt_ready", 64'(pkt_ready), 64'(1'b1));
    chk("rst_expected_bit", 64'(expected_bit), 64'(1'b0));
    chk("rst_m_valid", 64'(m_valid), 64'(1'b0));
    chk("rst_m_value", m_value, 64'h0);
    chk("rst_ack_tvalid", 64'(ack_tvalid), 64'(1'b0));
    chk("rst_ack_tdata", 64'(ack_tdata), 64'h0);
    chk("rst_ack_tlast", 64'(ack_tlast), 64'(1'b0));
    chk_cnts("rst", 0, 0, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_rel_ready", 64'(pkt_ready), 64'(1'b1));

    // First new packet: cycle-exact latency with both sinks ready
    pkt_valid = 1'b1;
    pkt_bit   = 1'b0;
    pkt_err   = 1'b0;
    pkt_value = 64'h0123_4567_89AB_CDEF;
    @(posedge aclk);
    #1;
    pkt_valid = 1'b0;
    pkt_value = '0;
    @(negedge aclk);
    chk("lat1_pkt_ready", 64'(pkt_ready), 64'(1'b0));
    chk("lat1_m_valid", 64'(m_valid), 64'(1'b0));
    chk("lat1_ack_tvalid", 64'(ack_tvalid), 64'(1'b0));
    @(negedge aclk);
    chk("lat2_m_valid", 64'(m_valid), 64'(1'b1));
    chk("lat2_m_value", m_value, 64'h0123_4567_89AB_CDEF);
    chk("lat2_ack_tvalid", 64'(ack_tvalid), 64'(1'b0));
    @(negedge aclk);
    chk("lat3_m_valid", 64'(m_valid), 64'(1'b0));
    chk("lat3_ack_tvalid", 64'(ack_tvalid), 64'(1'b1));
    chk("lat3_ack_tdata", 64'(ack_tdata), 64'hA0);
    chk("lat3_ack_tlast", 64'(ack_tlast), 64'(1'b1));
    chk("lat3_pkt_ready", 64'(pkt_ready), 64'(1'b0));
    chk("lat3_expected_bit", 64'(expected_bit), 64'(1'b0));
    @(negedge aclk);
    chk("lat4_pkt_ready", 64'(pkt_ready), 64'(1'b1));
    chk("lat4_ack_tvalid", 64'(ack_tvalid), 64'(1'b0));
    chk("lat4_ack_tlast", 64'(ack_tlast), 64'(1'b0));
    chk("lat4_expected_bit", 64'(expected_bit), 64'(1'b1));
    chk_cnts("lat4", 1, 0, 0);

    // Table: duplicate, alternation, backpressure, errors with saturation
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].b, vecs[i].e, vecs[i].v, vecs[i].mst, vecs[i].ast, ob);
      chk($sformatf("vec%0d_timeout", i), 64'(ob.timeout), 64'(1'b0));
      chk($sformatf("vec%0d_cycles", i), 64'(ob.cyc), 64'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_delivered", i), 64'(ob.del), 64'(vecs[i].exp_del));
      if (vecs[i].exp_del)
        chk($sformatf("vec%0d_m_value", i), ob.dval, vecs[i].v);
      chk($sformatf("vec%0d_acked", i), 64'(ob.ack), 64'(vecs[i].exp_ack));
      if (vecs[i].exp_ack) begin
        chk($sformatf("vec%0d_ack_tdata", i), 64'(ob.abyte), 64'(vecs[i].exp_byte));
        chk($sformatf("vec%0d_ack_tlast_bad", i), 64'(ob.alast_bad), 64'(1'b0));
      end
      chk($sformatf("vec%0d_unstable", i), 64'(ob.unstable), 64'(1'b0));
      chk($sformatf("vec%0d_order_bad", i), 64'(ob.order_bad), 64'(1'b0));
      chk($sformatf("vec%0d_expected_bit", i), 64'(expected_bit), 64'(vecs[i].exp_ebit));
      chk_cnts($sformatf("vec%0d", i), vecs[i].exp_new, vecs[i].exp_dup, vecs[i].exp_err);
    end

    // Reset in the middle of DELIVER (expected_bit is 1 at this point)
    @(negedge aclk);
    pkt_valid = 1'b1;
    pkt_bit   = 1'b1;
    pkt_err   = 1'b0;
    pkt_value = 64'hDEAD_BEEF_0000_0001;
    m_ready   = 1'b0;
    ack_tready = 1'b1;
    @(posedge aclk);
    #1;
    pkt_valid = 1'b0;
    for (int c = 0; c < 10 && !m_valid; c++) @(negedge aclk);
    chk("mid_in_deliver", 64'(m_valid), 64'(1'b1));
    #2 aresetn = 1'b0;
    #1;
    chk("mid_async_m_valid", 64'(m_valid), 64'(1'b0));
    chk("mid_async_m_value", m_value, 64'h0);
    chk("mid_async_pkt_ready", 64'(pkt_ready), 64'(1'b1));
    chk("mid_async_expected_bit", 64'(expected_bit), 64'(1'b0));
    chk("mid_async_ack_tvalid", 64'(ack_tvalid), 64'(1'b0));
    chk_cnts("mid_async", 0, 0, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("mid_rel_pkt_ready", 64'(pkt_ready), 64'(1'b1));
    chk("mid_rel_expected_bit", 64'(expected_bit), 64'(1'b0));
    chk("mid_rel_no_ack", 64'(ack_tvalid), 64'(1'b0));
    chk("mid_rel_no_m_valid", 64'(m_valid), 64'(1'b0));

    // Randomized traffic against a transaction-level model
    mexp = 1'b0;
    mnew = 0; mdup = 0; merr = 0; sent = 0;
    prev_mstall = 1'b0;
    prev_astall = 1'b0;
    prev_mval = '0;
    prev_abyte = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge aclk);
      if (m_valid && m_ready) begin
        if (dq.size() == 0) chk("rnd_unexpected_delivery", 64'(1'b1), 64'(1'b0));
        else chk("rnd_m_value", m_value, dq.pop_front());
      end
      if (prev_mstall) chk("rnd_m_value_stable", m_value, prev_mval);
      if (prev_astall) chk("rnd_ack_tdata_stable", 64'(ack_tdata), 64'(prev_abyte));
      if (ack_tvalid) begin
        chk("rnd_ack_tlast", 64'(ack_tlast), 64'(1'b1));
        chk("rnd_busy_pkt_ready", 64'(pkt_ready), 64'(1'b0));
        if (ack_tready) begin
          if (aq.size() == 0) chk("rnd_unexpected_ack", 64'(1'b1), 64'(1'b0));
          else chk("rnd_ack_tdata", 64'(ack_tdata), 64'(aq.pop_front()));
        end
      end
      if (pkt_ready) begin
        chk("rnd_expected_bit", 64'(expected_bit), 64'(mexp));
        chk_cnts("rnd", mnew, mdup, merr);
      end
      prev_mstall = m_valid && !m_ready;
      prev_astall = ack_tvalid && !ack_tready;
      prev_mval   = m_value;
      prev_abyte  = ack_tdata;
      acc = pkt_valid && pkt_ready;
      if (acc) begin
        if (pkt_err) merr++;
        else if (pkt_bit == mexp) begin
          dq.push_back(pkt_value);
          aq.push_back(8'hA0 | {7'd0, pkt_bit});
          mnew++;
          mexp = ~mexp;
        end else begin
          aq.push_back(8'hA0 | {7'd0, pkt_bit});
          mdup++;
        end
      end
      if (sent >= NRAND && !pkt_valid && pkt_ready && dq.size() == 0 && aq.size() == 0) break;
      @(posedge aclk);
      #1;
      if (acc) pkt_valid = 1'b0;
      if (!pkt_valid && sent < NRAND && $urandom_range(0, 2) == 0) begin
        pkt_valid = 1'b1;
        pkt_bit   = 1'($urandom_range(0, 1));
        pkt_err   = ($urandom_range(0, 7) == 0);
        pkt_value = {$urandom, $urandom};
        sent++;
      end
      m_ready    = ($urandom_range(0, 3) != 0);
      ack_tready = ($urandom_range(0, 3) != 0);
    end
    chk("rnd_all_sent", 64'(sent), 64'(NRAND));
    chk("rnd_drained", 64'(dq.size() + aq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
